// File: rtl/ex_pkg.sv
// Shared encodings for the EX/MEM stage: ALUOp field values, ALU operations
// and the branch FUNC3 compare codes.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_ADDX = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Immediate forms never subtract: FUNC7[5] only selects SUB for register operands.
    function automatic alu_op_e alu_decode(
        input logic [1:0] aluop,
        input logic [2:0] func3,
        input logic       func7_5,
        input logic       alusrc
    );
        alu_op_e op;
        op = ALU_ADD;
        case (aluop)
            ALUOP_ADD, ALUOP_ADDX: op = ALU_ADD;
            ALUOP_SUB:             op = ALU_SUB;
            ALUOP_FUNC: begin
                case (func3)
                    3'b000: begin
                        if (func7_5 && !alusrc) op = ALU_SUB;
                        else                    op = ALU_ADD;
                    end
                    3'b001: op = ALU_SLL;
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b101: begin
                        if (func7_5) op = ALU_SRA;
                        else         op = ALU_SRL;
                    end
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    default: op = ALU_ADD;
                endcase
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU for the execute stage; shift amount is operand B[4:0].
module ex_alu
    import ex_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        result_o = '0;
        case (alu_op_e'(op_i))
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'b0, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: ALU, branch resolution with one-slot wrong-path kill,
// stall/flush handling and retired/taken counters. State advances on negedge CLK.
module ex_mem_stage
    import ex_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        IN_VALID,
    input  logic [31:0] IN_PC,
    input  logic [5:0]  IN_RD,
    input  logic [2:0]  IN_FUNC3,
    input  logic [6:0]  IN_FUNC7,
    input  logic [1:0]  IN_ALUOp,
    input  logic        IN_ALUSrc,
    input  logic        IN_Branch,
    input  logic        IN_MemRead,
    input  logic        IN_MemWrite,
    input  logic        IN_RegWrite,
    input  logic        IN_MemToReg,
    input  logic [31:0] IN_READ_DATA_1,
    input  logic [31:0] IN_READ_DATA_2,
    input  logic [31:0] IN_IMM,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    output logic [31:0] OUT_ALU_RESULT,
    output logic [31:0] OUT_WRITE_DATA,
    output logic [5:0]  OUT_RD,
    output logic        OUT_MemRead,
    output logic        OUT_MemWrite,
    output logic        OUT_RegWrite,
    output logic        OUT_MemToReg,
    output logic        OUT_BRANCH_TAKEN,
    output logic [31:0] OUT_BRANCH_TARGET,
    output logic [31:0] OUT_RETIRED,
    output logic [31:0] OUT_TAKEN_CNT
);

    logic        valid_q,    valid_d;
    logic [31:0] alu_q,      alu_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [5:0]  rd_q,       rd_d;
    logic        memread_q,  memread_d;
    logic        memwrite_q, memwrite_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        taken_q,    taken_d;
    logic [31:0] target_q,   target_d;
    logic [31:0] retired_q,  retired_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic        kill_q,     kill_d;

    alu_op_e     alu_op;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        br_cond;
    logic        br_taken;
    logic        accept;
    logic        func7_unused;

    assign func7_unused = ^{IN_FUNC7[6], IN_FUNC7[4:0]};

    assign alu_op = alu_decode(IN_ALUOp, IN_FUNC3, IN_FUNC7[5], IN_ALUSrc);
    assign op_b   = IN_ALUSrc ? IN_IMM : IN_READ_DATA_2;

    ex_alu u_alu (
        .op_i     (alu_op),
        .a_i      (IN_READ_DATA_1),
        .b_i      (op_b),
        .result_o (alu_result)
    );

    always_comb begin
        br_cond = 1'b0;
        case (IN_FUNC3)
            BR_EQ:   br_cond = (IN_READ_DATA_1 == IN_READ_DATA_2);
            BR_NE:   br_cond = (IN_READ_DATA_1 != IN_READ_DATA_2);
            BR_LT:   br_cond = ($signed(IN_READ_DATA_1) <  $signed(IN_READ_DATA_2));
            BR_GE:   br_cond = ($signed(IN_READ_DATA_1) >= $signed(IN_READ_DATA_2));
            BR_LTU:  br_cond = (IN_READ_DATA_1 <  IN_READ_DATA_2);
            BR_GEU:  br_cond = (IN_READ_DATA_1 >= IN_READ_DATA_2);
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken = IN_Branch & br_cond;
    assign accept   = IN_VALID & ~kill_q & ~STALL & ~FLUSH;

    // FLUSH outranks STALL; a kill-bubbled or invalid slot clears controls like a flush.
    always_comb begin
        valid_d     = valid_q;
        alu_d       = alu_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        memread_d   = memread_q;
        memwrite_d  = memwrite_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        taken_d     = 1'b0;
        target_d    = target_q;
        retired_d   = retired_q;
        taken_cnt_d = taken_cnt_q;
        kill_d      = kill_q;

        if (FLUSH || (!STALL && !accept)) begin
            valid_d    = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            kill_d     = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            alu_d      = alu_result;
            wdata_d    = IN_READ_DATA_2;
            rd_d       = IN_RD;
            memread_d  = IN_MemRead;
            memwrite_d = IN_MemWrite;
            regwrite_d = IN_RegWrite;
            memtoreg_d = IN_MemToReg;
            taken_d    = br_taken;
            kill_d     = br_taken;
            retired_d  = retired_q + 32'd1;
            if (br_taken) begin
                target_d    = IN_PC + IN_IMM;
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(negedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            valid_q     <= 1'b0;
            alu_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            retired_q   <= '0;
            taken_cnt_q <= '0;
            kill_q      <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_q       <= alu_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            retired_q   <= retired_d;
            taken_cnt_q <= taken_cnt_d;
            kill_q      <= kill_d;
        end
    end

    assign OUT_VALID         = valid_q;
    assign OUT_ALU_RESULT    = alu_q;
    assign OUT_WRITE_DATA    = wdata_q;
    assign OUT_RD            = rd_q;
    assign OUT_MemRead       = memread_q;
    assign OUT_MemWrite      = memwrite_q;
    assign OUT_RegWrite      = regwrite_q;
    assign OUT_MemToReg      = memtoreg_q;
    assign OUT_BRANCH_TAKEN  = taken_q;
    assign OUT_BRANCH_TARGET = target_q;
    assign OUT_RETIRED       = retired_q;
    assign OUT_TAKEN_CNT     = taken_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, hand-written stall/flush/reset/wrap
// sequences, then randomized traffic against an instruction-level reference model.
module tb_ex_mem_stage;

    logic        CLK;
    logic        RSTN;
    logic        IN_VALID;
    logic [31:0] IN_PC;
    logic [5:0]  IN_RD;
    logic [2:0]  IN_FUNC3;
    logic [6:0]  IN_FUNC7;
    logic [1:0]  IN_ALUOp;
    logic        IN_ALUSrc;
    logic        IN_Branch;
    logic        IN_MemRead;
    logic        IN_MemWrite;
    logic        IN_RegWrite;
    logic        IN_MemToReg;
    logic [31:0] IN_READ_DATA_1;
    logic [31:0] IN_READ_DATA_2;
    logic [31:0] IN_IMM;
    logic        STALL;
    logic        FLUSH;
    logic        OUT_VALID;
    logic [31:0] OUT_ALU_RESULT;
    logic [31:0] OUT_WRITE_DATA;
    logic [5:0]  OUT_RD;
    logic        OUT_MemRead;
    logic        OUT_MemWrite;
    logic        OUT_RegWrite;
    logic        OUT_MemToReg;
    logic        OUT_BRANCH_TAKEN;
    logic [31:0] OUT_BRANCH_TARGET;
    logic [31:0] OUT_RETIRED;
    logic [31:0] OUT_TAKEN_CNT;

    ex_mem_stage dut (
        .CLK               (CLK),
        .RSTN              (RSTN),
        .IN_VALID          (IN_VALID),
        .IN_PC             (IN_PC),
        .IN_RD             (IN_RD),
        .IN_FUNC3          (IN_FUNC3),
        .IN_FUNC7          (IN_FUNC7),
        .IN_ALUOp          (IN_ALUOp),
        .IN_ALUSrc         (IN_ALUSrc),
        .IN_Branch         (IN_Branch),
        .IN_MemRead        (IN_MemRead),
        .IN_MemWrite       (IN_MemWrite),
        .IN_RegWrite       (IN_RegWrite),
        .IN_MemToReg       (IN_MemToReg),
        .IN_READ_DATA_1    (IN_READ_DATA_1),
        .IN_READ_DATA_2    (IN_READ_DATA_2),
        .IN_IMM            (IN_IMM),
        .STALL             (STALL),
        .FLUSH             (FLUSH),
        .OUT_VALID         (OUT_VALID),
        .OUT_ALU_RESULT    (OUT_ALU_RESULT),
        .OUT_WRITE_DATA    (OUT_WRITE_DATA),
        .OUT_RD            (OUT_RD),
        .OUT_MemRead       (OUT_MemRead),
        .OUT_MemWrite      (OUT_MemWrite),
        .OUT_RegWrite      (OUT_RegWrite),
        .OUT_MemToReg      (OUT_MemToReg),
        .OUT_BRANCH_TAKEN  (OUT_BRANCH_TAKEN),
        .OUT_BRANCH_TARGET (OUT_BRANCH_TARGET),
        .OUT_RETIRED       (OUT_RETIRED),
        .OUT_TAKEN_CNT     (OUT_TAKEN_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  aluop;
        logic        src;
        logic        br;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        stall;
        logic        flush;
    } in_t;

    typedef struct {
        in_t         in;
        logic        e_valid;
        logic [31:0] e_alu;
        logic [5:0]  e_rd;
        logic        e_bt;
        logic [31:0] e_tgt;
        logic [31:0] e_ret;
        logic [31:0] e_tc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic        m_valid, m_mr, m_mw, m_rw, m_m2r, m_bt, m_kill;
    logic [31:0] m_alu, m_wd, m_tgt, m_ret, m_tc;
    logic [5:0]  m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic src,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint      sa, sb, ua, ub;
        logic [31:0] r;
        sh = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        r  = 32'h0;
        if (op == 2'b01)      r = a + (~b) + 1;
        else if (op != 2'b10) r = a + b;
        else begin
            case (f3)
                3'd0: r = (f7[5] && !src) ? a + (~b) + 1 : a + b;
                3'd1: r = a << sh;
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    r = a >> sh;
                    if (f7[5] && a[31]) r = r | ~(32'hFFFFFFFF >> sh);
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return r;
    endfunction

    function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_bt = 0; m_kill = 0;
        m_alu = 0; m_wd = 0; m_tgt = 0; m_ret = 0; m_tc = 0; m_rd = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_bt = 0; m_kill = 0;
    endtask

    // One clock edge of the stage as seen from the instruction stream.
    task automatic model_edge(input in_t x);
        logic tk;
        if (x.flush) model_bubble();
        else if (x.stall) m_bt = 0;
        else if (x.valid && !m_kill) begin
            tk      = x.br && ref_branch(x.f3, x.a, x.b);
            m_valid = 1;
            m_alu   = ref_alu(x.aluop, x.f3, x.f7, x.src, x.a, x.src ? x.imm : x.b);
            m_wd    = x.b;
            m_rd    = x.rd;
            m_mr    = x.mr; m_mw = x.mw; m_rw = x.rw; m_m2r = x.m2r;
            m_bt    = tk;
            m_kill  = tk;
            m_ret   = m_ret + 1;
            if (tk) begin
                m_tgt = x.pc + x.imm;
                m_tc  = m_tc + 1;
            end
        end else model_bubble();
    endtask

    task automatic drive(input in_t x);
        IN_VALID = x.valid; IN_PC = x.pc; IN_RD = x.rd; IN_FUNC3 = x.f3; IN_FUNC7 = x.f7;
        IN_ALUOp = x.aluop; IN_ALUSrc = x.src; IN_Branch = x.br; IN_MemRead = x.mr;
        IN_MemWrite = x.mw; IN_RegWrite = x.rw; IN_MemToReg = x.m2r;
        IN_READ_DATA_1 = x.a; IN_READ_DATA_2 = x.b; IN_IMM = x.imm;
        STALL = x.stall; FLUSH = x.flush;
    endtask

    task automatic step(input in_t x);
        drive(x);
        model_edge(x);
        @(negedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},    32'(OUT_VALID),         32'(m_valid));
        chk({tag, ".alu"},      OUT_ALU_RESULT,         m_alu);
        chk({tag, ".wdata"},    OUT_WRITE_DATA,         m_wd);
        chk({tag, ".rd"},       32'(OUT_RD),            32'(m_rd));
        chk({tag, ".memread"},  32'(OUT_MemRead),       32'(m_mr));
        chk({tag, ".memwrite"}, 32'(OUT_MemWrite),      32'(m_mw));
        chk({tag, ".regwrite"}, 32'(OUT_RegWrite),      32'(m_rw));
        chk({tag, ".memtoreg"}, 32'(OUT_MemToReg),      32'(m_m2r));
        chk({tag, ".taken"},    32'(OUT_BRANCH_TAKEN),  32'(m_bt));
        chk({tag, ".target"},   OUT_BRANCH_TARGET,      m_tgt);
        chk({tag, ".retired"},  OUT_RETIRED,            m_ret);
        chk({tag, ".takencnt"}, OUT_TAKEN_CNT,          m_tc);
    endtask

    function automatic in_t mk(input logic v, input logic [1:0] aluop, input logic [2:0] f3,
                               input logic [6:0] f7, input logic src, input logic br,
                               input logic rw, input logic [5:0] rd, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc);
        in_t x;
        x.valid = v; x.aluop = aluop; x.f3 = f3; x.f7 = f7; x.src = src; x.br = br;
        x.rw = rw; x.rd = rd; x.a = a; x.b = b; x.imm = imm; x.pc = pc;
        x.mr = 0; x.mw = 0; x.m2r = 0; x.stall = 0; x.flush = 0;
        return x;
    endfunction

    function automatic vec_t row(input in_t x, input logic v, input logic [31:0] alu,
                                 input logic [5:0] rd, input logic bt, input logic [31:0] tgt,
                                 input logic [31:0] ret, input logic [31:0] tc);
        vec_t r;
        r.in = x; r.e_valid = v; r.e_alu = alu; r.e_rd = rd; r.e_bt = bt;
        r.e_tgt = tgt; r.e_ret = ret; r.e_tc = tc;
        return r;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x.valid = ($urandom_range(0, 99) < 85);
        x.aluop = 2'($urandom_range(0, 3));
        x.f3    = 3'($urandom_range(0, 7));
        x.f7    = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom_range(0, 127));
        x.src   = 1'($urandom_range(0, 1));
        x.br    = ($urandom_range(0, 2) == 0);
        x.mr    = 1'($urandom_range(0, 1));
        x.mw    = 1'($urandom_range(0, 1));
        x.rw    = 1'($urandom_range(0, 1));
        x.m2r   = 1'($urandom_range(0, 1));
        x.rd    = 6'($urandom_range(0, 63));
        x.pc    = $urandom;
        x.a     = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
        x.b     = ($urandom_range(0, 3) == 0) ? x.a : $urandom;
        x.imm   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(12'($urandom)));
        x.stall = ($urandom_range(0, 99) < 15);
        x.flush = ($urandom_range(0, 99) < 8);
        return x;
    endfunction

    vec_t tbl[12];

    initial begin
        in_t x;
        logic [31:0] ret_before;

        tbl[0]  = row(mk(1, 2'b10, 3'b000, 7'h00, 0, 0, 1, 6'd3, 32'd5, 32'd7, 32'd0, 32'h0),
                      1, 32'd12, 6'd3, 0, 32'h0, 32'd1, 32'd0);
        tbl[1]  = row(mk(1, 2'b10, 3'b101, 7'h20, 0, 0, 1, 6'd4, 32'h80000000, 32'd4, 32'd0, 32'h0),
                      1, 32'hF8000000, 6'd4, 0, 32'h0, 32'd2, 32'd0);
        tbl[2]  = row(mk(1, 2'b10, 3'b000, 7'h20, 0, 0, 1, 6'd5, 32'd0, 32'd1, 32'd0, 32'h0),
                      1, 32'hFFFFFFFF, 6'd5, 0, 32'h0, 32'd3, 32'd0);
        tbl[3]  = row(mk(1, 2'b01, 3'b000, 7'h00, 0, 1, 0, 6'd0, 32'd9, 32'd9, 32'h20, 32'h100),
                      1, 32'd0, 6'd0, 1, 32'h120, 32'd4, 32'd1);
        tbl[4]  = row(mk(1, 2'b10, 3'b000, 7'h00, 0, 0, 1, 6'd6, 32'd1, 32'd1, 32'd0, 32'h104),
                      0, 32'd0, 6'd0, 0, 32'h120, 32'd4, 32'd1);
        tbl[5]  = row(mk(1, 2'b10, 3'b000, 7'h00, 0, 0, 1, 6'd6, 32'd1, 32'd1, 32'd0, 32'h120),
                      1, 32'd2, 6'd6, 0, 32'h120, 32'd5, 32'd1);
        tbl[6]  = row(mk(1, 2'b10, 3'b011, 7'h00, 0, 0, 1, 6'd7, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h0),
                      1, 32'd1, 6'd7, 0, 32'h120, 32'd6, 32'd1);
        tbl[7]  = row(mk(1, 2'b10, 3'b010, 7'h00, 0, 0, 1, 6'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0),
                      1, 32'd1, 6'd8, 0, 32'h120, 32'd7, 32'd1);
        tbl[8]  = row(mk(1, 2'b00, 3'b000, 7'h00, 1, 0, 1, 6'd9, 32'd10, 32'd99, 32'hFFFFFFFD, 32'h0),
                      1, 32'd7, 6'd9, 0, 32'h120, 32'd8, 32'd1);
        tbl[9]  = row(mk(1, 2'b10, 3'b000, 7'h20, 1, 0, 1, 6'd10, 32'd10, 32'd99, 32'd3, 32'h0),
                      1, 32'd13, 6'd10, 0, 32'h120, 32'd9, 32'd1);
        tbl[10] = row(mk(1, 2'b01, 3'b001, 7'h00, 0, 1, 0, 6'd0, 32'd4, 32'd4, 32'h40, 32'h200),
                      1, 32'd0, 6'd0, 0, 32'h120, 32'd10, 32'd1);
        tbl[11] = row(mk(0, 2'b10, 3'b000, 7'h00, 0, 0, 1, 6'd12, 32'd3, 32'd3, 32'd0, 32'h0),
                      0, 32'd0, 6'd0, 0, 32'h120, 32'd10, 32'd1);

        RSTN = 1'b0;
        drive(mk(0, 2'b00, 3'b000, 7'h00, 0, 0, 0, 6'd0, 32'd0, 32'd0, 32'd0, 32'h0));
        model_reset();
        #3;
        check_all("reset");
        #4 RSTN = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].in);
            chk($sformatf("vec%0d.valid", i),   32'(OUT_VALID),        32'(tbl[i].e_valid));
            chk($sformatf("vec%0d.alu", i),     OUT_ALU_RESULT,        tbl[i].e_alu);
            chk($sformatf("vec%0d.rd", i),      32'(OUT_RD),           32'(tbl[i].e_rd));
            chk($sformatf("vec%0d.taken", i),   32'(OUT_BRANCH_TAKEN), 32'(tbl[i].e_bt));
            chk($sformatf("vec%0d.target", i),  OUT_BRANCH_TARGET,     tbl[i].e_tgt);
            chk($sformatf("vec%0d.retired", i), OUT_RETIRED,           tbl[i].e_ret);
            chk($sformatf("vec%0d.takencnt", i), OUT_TAKEN_CNT,        tbl[i].e_tc);
        end

        // Stall held for three cycles after a load-like ADD, then FLUSH together with STALL.
        x = mk(1, 2'b10, 3'b000, 7'h00, 0, 0, 1, 6'd11, 32'd3, 32'd4, 32'd0, 32'h0);
        x.mr = 1; x.m2r = 1;
        step(x);
        check_all("stall_pre");
        chk("stall_pre.alu_const", OUT_ALU_RESULT, 32'd7);
        ret_before = OUT_RETIRED;
        for (int i = 0; i < 3; i++) begin
            x = rand_in();
            x.valid = 1; x.stall = 1; x.flush = 0;
            step(x);
            check_all($sformatf("stall%0d", i));
            chk($sformatf("stall%0d.alu_const", i), OUT_ALU_RESULT, 32'd7);
            chk($sformatf("stall%0d.ret_hold", i), OUT_RETIRED, ret_before);
        end
        x = rand_in();
        x.valid = 1; x.stall = 1; x.flush = 1;
        step(x);
        check_all("flush_stall");
        chk("flush_stall.valid0", 32'(OUT_VALID), 32'd0);
        chk("flush_stall.ctrl0", 32'({OUT_MemRead, OUT_MemWrite, OUT_RegWrite, OUT_MemToReg}), 32'd0);
        chk("flush_stall.alu_hold", OUT_ALU_RESULT, 32'd7);

        // Asynchronous reset between edges while KILL is pending.
        step(mk(1, 2'b01, 3'b000, 7'h00, 0, 1, 0, 6'd0, 32'd5, 32'd5, 32'h8, 32'h300));
        check_all("kill_br");
        #2 RSTN = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        #1 RSTN = 1'b1;
        step(mk(1, 2'b10, 3'b000, 7'h00, 0, 0, 1, 6'd1, 32'd2, 32'd2, 32'd0, 32'h0));
        check_all("post_rst");
        chk("post_rst.valid", 32'(OUT_VALID), 32'd1);
        chk("post_rst.alu", OUT_ALU_RESULT, 32'd4);
        chk("post_rst.retired", OUT_RETIRED, 32'd1);

        // Counter wrap via preloaded state.
        force dut.retired_q = 32'hFFFFFFFF;
        force dut.taken_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        release dut.taken_cnt_q;
        m_ret = 32'hFFFFFFFF;
        m_tc  = 32'hFFFFFFFF;
        chk("wrap.preload", OUT_RETIRED, 32'hFFFFFFFF);
        step(mk(1, 2'b01, 3'b110, 7'h00, 0, 1, 0, 6'd0, 32'd1, 32'd2, 32'h10, 32'h400));
        check_all("wrap");
        chk("wrap.retired0", OUT_RETIRED, 32'd0);
        chk("wrap.takencnt0", OUT_TAKEN_CNT, 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(rand_in());
            check_all($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have one clock and one reset: CLK input 1 (sole clock; all state updates on negedge CLK, matching the upstream pipeline register), RSTN input 1 (asynchronous, active-low reset).
REQ-002 SHALL have inputs from ID/EX: IN_VALID 1, IN_PC 32, IN_RD 6, IN_FUNC3 3, IN_FUNC7 7, IN_ALUOp 2, IN_ALUSrc 1, IN_Branch 1, IN_MemRead 1, IN_MemWrite 1, IN_RegWrite 1, IN_MemToReg 1, IN_READ_DATA_1 32, IN_READ_DATA_2 32, IN_IMM 32 (sign-extended, byte offset).
REQ-003 SHALL have hazard-control inputs: STALL 1 (hold stage), FLUSH 1 (insert bubble).
REQ-004 SHALL have EX/MEM outputs: OUT_VALID 1, OUT_ALU_RESULT 32, OUT_WRITE_DATA 32 (store data), OUT_RD 6, OUT_MemRead 1, OUT_MemWrite 1, OUT_RegWrite 1, OUT_MemToReg 1.
REQ-005 SHALL have redirect and count outputs: OUT_BRANCH_TAKEN 1 (one-cycle pulse), OUT_BRANCH_TARGET 32, OUT_RETIRED 32 (valid instructions passed), OUT_TAKEN_CNT 32 (taken branches).

Function
REQ-006 SHALL select operand B = IN_IMM when IN_ALUSrc=1, else IN_READ_DATA_2; operand A = IN_READ_DATA_1.
REQ-007 SHALL decode ALUOp: 00 ADD; 01 SUB; 11 ADD; 10 by FUNC3: 000 ADD, or SUB when FUNC7[5]=1 and ALUSrc=0; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL, or SRA when FUNC7[5]=1; 110 OR; 111 AND.
REQ-008 SHALL use shift amount B[4:0]; all add/sub wrap modulo 2^32; SLT/SLTU yield 32'h0 or 32'h1.
REQ-009 SHALL evaluate branch condition when IN_Branch=1 by FUNC3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 never taken.
REQ-010 SHALL compute target = IN_PC + IN_IMM modulo 2^32, registered to OUT_BRANCH_TARGET on every taken branch and held otherwise.
REQ-011 SHALL define accept = IN_VALID & !KILL & !STALL & !FLUSH, with latency one clock from input to registered output.
REQ-012 On accept, SHALL register ALU result, IN_READ_DATA_2 to OUT_WRITE_DATA, RD, and memory/writeback controls, and set OUT_VALID=1.
REQ-013 When FLUSH=1 (priority over STALL), SHALL set OUT_VALID=0 and clear OUT_MemRead, OUT_MemWrite, OUT_RegWrite, OUT_MemToReg and OUT_BRANCH_TAKEN; data outputs SHALL hold.
REQ-014 When STALL=1 and FLUSH=0, SHALL hold all outputs except OUT_BRANCH_TAKEN, which SHALL be 0; counters SHALL hold.
REQ-015 When IN_VALID=0 or KILL=1 with no STALL/FLUSH, SHALL produce a bubble as in REQ-013.
REQ-016 SHALL assert OUT_BRANCH_TAKEN for exactly one cycle after accepting a branch with a true condition.
REQ-017 SHALL hold internal flag KILL, set on a taken-branch accept and cleared on the next non-stalled edge; the wrong-path instruction presented in that cycle SHALL be bubbled. FLUSH SHALL also clear KILL.
REQ-018 SHALL increment OUT_RETIRED on each accept and OUT_TAKEN_CNT on each taken-branch accept; both wrap from 32'hFFFFFFFF to 0.
REQ-019 Branch instructions SHALL still pass their controls through; a branch with RegWrite=0 produces no writeback.

Reset
REQ-020 RSTN low SHALL immediately clear all outputs, KILL and both counters to 0, regardless of CLK.
REQ-021 Reset asserted mid-stall or mid-KILL SHALL discard the pending state; the first edge after release SHALL behave as a fresh pipeline.

Structure
REQ-022 Package ex_pkg SHALL hold the ALUOp encodings, the ALU operation enum and the branch FUNC3 constants.
REQ-023 Combinational sub-module ex_alu (operands, op -> result) SHALL be instantiated once; branch compare, registers, KILL and counters stay in ex_mem_stage.

Verification
REQ-024 ADD R-type: RD1=5, RD2=7, ALUOp=10, F3=000, F7=0, RD=3, RegWrite=1 -> next cycle OUT_ALU_RESULT=12, OUT_RD=3, OUT_VALID=1, OUT_RETIRED=1.
REQ-025 SUB/SRA: RD1=32'h80000000, RD2=4, F3=101, F7=0100000 -> 32'hF8000000; F3=000, F7[5]=1, RD1=0, RD2=1 -> 32'hFFFFFFFF.
REQ-026 BEQ taken: PC=0x100, IMM=0x20, RD1=RD2=9 -> OUT_BRANCH_TAKEN=1 for one cycle, TARGET=0x120, next valid input bubbled, then the following one accepted.
REQ-027 STALL held 3 cycles after a valid ADD -> outputs stable, counters unchanged; FLUSH with STALL -> OUT_VALID=0, all controls 0.
REQ-028 Async reset pulse between edges during KILL -> all outputs 0 at once; first post-reset instruction accepted.
REQ-029 Counter wrap: preload via 2^32-1 accepts or force -> next accept gives OUT_RETIRED=0.
